// File: rtl/fd_arbiter.sv
// Round-robin front end that shares one combinational fast_divider among NUM_REQ clients.
// Grants one request at a time, registers its operands, captures the result and returns it tagged with the ID.
module fd_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic                     resp_valid_out,
  input  logic                     resp_ready_in,
  output logic [ID_W-1:0]          resp_id_out,
  output logic [WIDTH-1:0]         resp_quotient_out,
  output logic [WIDTH-1:0]         resp_remainder_out,
  output logic                     resp_dbz_out,
  output logic                     busy_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_dbz_in
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  dividend_q, divisor_q;
  logic [WIDTH-1:0]  quotient_q, remainder_q;
  logic              dbz_q;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  sel_dividend, sel_divisor;
  logic              accept, resp_done;

  // Round-robin pick: lowest valid index at or above the pointer, else lowest valid overall.
  always_comb begin
    logic            hi_vld, lo_vld;
    logic [ID_W-1:0] hi_idx, lo_idx;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid_in[i]) begin
        lo_vld = 1'b1;
        lo_idx = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
    grant_vld = lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_dividend = req_dividend_in[i*WIDTH +: WIDTH];
        sel_divisor  = req_divisor_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept    = (state_q == IDLE) && grant_vld;
  assign resp_done = (state_q == RESP) && resp_ready_in;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (resp_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready_out  = '0;
    resp_valid_out = 1'b0;
    busy_out       = 1'b0;
    case (state_q)
      IDLE: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready_out[i] = grant_vld && (ID_W'(i) == grant_idx);
        end
      end
      CALC: busy_out = 1'b1;
      RESP: begin
        busy_out       = 1'b1;
        resp_valid_out = 1'b1;
      end
      default: busy_out = 1'b1;
    endcase
  end

  // Datapath: operands held after use so the divider inputs stay quiet while idle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q       <= '0;
      id_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      if (accept) begin
        id_q       <= grant_idx;
        dividend_q <= sel_dividend;
        divisor_q  <= sel_divisor;
      end
      if (state_q == CALC) begin
        quotient_q  <= div_quotient_in;
        remainder_q <= div_remainder_in;
        dbz_q       <= div_dbz_in;
      end
      if (resp_done) begin
        ptr_q <= (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
      end
    end
  end

  assign div_dividend_out   = dividend_q;
  assign div_divisor_out    = divisor_q;
  assign resp_id_out        = id_q;
  assign resp_quotient_out  = quotient_q;
  assign resp_remainder_out = remainder_q;
  assign resp_dbz_out       = dbz_q;

endmodule

// File: tb/tb_fd_arbiter.sv
// Directed bench for fd_arbiter with a behavioural divider model standing in for fast_divider.
module tb_fd_arbiter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [NUM_REQ*WIDTH-1:0] req_dividend_in;
  logic [NUM_REQ*WIDTH-1:0] req_divisor_in;
  logic                     resp_valid_out;
  logic                     resp_ready_in;
  logic [ID_W-1:0]          resp_id_out;
  logic [WIDTH-1:0]         resp_quotient_out;
  logic [WIDTH-1:0]         resp_remainder_out;
  logic                     resp_dbz_out;
  logic                     busy_out;
  logic [WIDTH-1:0]         div_dividend_out;
  logic [WIDTH-1:0]         div_divisor_out;
  logic [WIDTH-1:0]         div_quotient_in;
  logic [WIDTH-1:0]         div_remainder_in;
  logic                     div_dbz_in;

  int n_checks = 0;
  int n_fail   = 0;

  fd_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_dividend_in(req_dividend_in), .req_divisor_in(req_divisor_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_id_out(resp_id_out), .resp_quotient_out(resp_quotient_out),
    .resp_remainder_out(resp_remainder_out), .resp_dbz_out(resp_dbz_out),
    .busy_out(busy_out),
    .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
    .div_quotient_in(div_quotient_in), .div_remainder_in(div_remainder_in),
    .div_dbz_in(div_dbz_in)
  );

  always #5 clk_in = ~clk_in;

  // Divider stand-in: x/0 gives all-ones quotient, remainder = dividend, dbz set.
  always_comb begin
    div_dbz_in       = (div_divisor_out == '0);
    div_quotient_in  = div_dbz_in ? '1 : div_dividend_out / div_divisor_out;
    div_remainder_in = div_dbz_in ? div_dividend_out : div_dividend_out % div_divisor_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    req_dividend_in[i*WIDTH +: WIDTH] = dvd;
    req_divisor_in[i*WIDTH +: WIDTH]  = dvs;
  endtask

  initial begin
    logic [NUM_REQ-1:0] onehot;
    int                 exp_id;
    int                 dvd, dvs;

    rst_in          = 1'b1;
    req_valid_in    = '0;
    resp_ready_in   = 1'b0;
    req_dividend_in = '0;
    req_divisor_in  = '0;

    // Reset state
    tick(); tick();
    rst_in = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready_out), 0);
    check("rst_valid", 32'(resp_valid_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_id", 32'(resp_id_out), 0);
    check("rst_quot", 32'(resp_quotient_out), 0);
    check("rst_rem", 32'(resp_remainder_out), 0);
    check("rst_dbz", 32'(resp_dbz_out), 0);
    check("rst_div_dvd", 32'(div_dividend_out), 0);
    check("rst_div_dvs", 32'(div_divisor_out), 0);

    // Single request: requester 2, 100/7
    set_ops(2, 8'd100, 8'd7);
    req_valid_in = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready_out), 32'h4);
    tick();
    req_valid_in = '0;
    #1;
    check("single_calc_busy", 32'(busy_out), 1);
    check("single_calc_valid", 32'(resp_valid_out), 0);
    check("single_calc_ready", 32'(req_ready_out), 0);
    check("single_div_dvd", 32'(div_dividend_out), 100);
    check("single_div_dvs", 32'(div_divisor_out), 7);
    tick();
    check("single_resp_valid", 32'(resp_valid_out), 1);
    check("single_resp_id", 32'(resp_id_out), 2);
    check("single_resp_quot", 32'(resp_quotient_out), 14);
    check("single_resp_rem", 32'(resp_remainder_out), 2);
    check("single_resp_dbz", 32'(resp_dbz_out), 0);
    resp_ready_in = 1'b1;
    tick();
    resp_ready_in = 1'b0;
    check("single_done_valid", 32'(resp_valid_out), 0);
    check("single_done_busy", 32'(busy_out), 0);
    check("single_hold_dvd", 32'(div_dividend_out), 100);

    // Divide by zero: requester 1, 55/0 (pointer now 3, search 3,0,1)
    set_ops(1, 8'd55, 8'd0);
    req_valid_in = 4'b0010;
    #1;
    check("dbz_ready", 32'(req_ready_out), 32'h2);
    tick();
    req_valid_in = '0;
    tick();
    check("dbz_valid", 32'(resp_valid_out), 1);
    check("dbz_flag", 32'(resp_dbz_out), 1);
    check("dbz_id", 32'(resp_id_out), 1);
    check("dbz_quot", 32'(resp_quotient_out), 32'hFF);
    check("dbz_rem", 32'(resp_remainder_out), 55);
    resp_ready_in = 1'b1;
    tick();
    resp_ready_in = 1'b0;

    // Re-reset so contention starts from pointer 0
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;

    // Contention: all valid, resp_ready tied high -> grants 0,1,2,3,0, one per 3 cycles
    for (int i = 0; i < 4; i++) set_ops(i, 8'(20*(i+1)+3), 8'(i+2));
    req_valid_in  = 4'b1111;
    resp_ready_in = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      dvd    = 20*(exp_id+1)+3;
      dvs    = exp_id+2;
      onehot = 4'b0001 << exp_id;
      #1;
      check($sformatf("cont%0d_ready", g), 32'(req_ready_out), 32'(onehot));
      tick();
      check($sformatf("cont%0d_calc_ready", g), 32'(req_ready_out), 0);
      tick();
      check($sformatf("cont%0d_valid", g), 32'(resp_valid_out), 1);
      check($sformatf("cont%0d_id", g), 32'(resp_id_out), 32'(exp_id));
      check($sformatf("cont%0d_quot", g), 32'(resp_quotient_out), 32'(dvd / dvs));
      check($sformatf("cont%0d_rem", g), 32'(resp_remainder_out), 32'(dvd % dvs));
      tick();
    end

    // Backpressure: pointer now 1, consumer stalls 5 cycles
    resp_ready_in = 1'b0;
    #1;
    check("bp_ready", 32'(req_ready_out), 32'h2);
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_valid", c), 32'(resp_valid_out), 1);
      check($sformatf("bp%0d_id", c), 32'(resp_id_out), 1);
      check($sformatf("bp%0d_quot", c), 32'(resp_quotient_out), 32'(43 / 3));
      check($sformatf("bp%0d_rem", c), 32'(resp_remainder_out), 32'(43 % 3));
      check($sformatf("bp%0d_ready", c), 32'(req_ready_out), 0);
      check($sformatf("bp%0d_busy", c), 32'(busy_out), 1);
      tick();
    end
    resp_ready_in = 1'b1;
    #1;
    check("bp_hs_ready", 32'(req_ready_out), 0);
    tick();
    resp_ready_in = 1'b0;
    check("bp_next_ready", 32'(req_ready_out), 32'h4);
    req_valid_in = '0;
    #1;
    check("bp_withdraw_ready", 32'(req_ready_out), 0);
    tick();
    check("bp_withdraw_busy", 32'(busy_out), 0);

    // Reset during CALC of requester 3 (pointer 2, search 2,3)
    req_valid_in = 4'b1000;
    #1;
    check("rmid_ready", 32'(req_ready_out), 32'h8);
    tick();
    req_valid_in = '0;
    check("rmid_calc_busy", 32'(busy_out), 1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("rmid_valid", 32'(resp_valid_out), 0);
    check("rmid_busy", 32'(busy_out), 0);
    tick();
    check("rmid_valid2", 32'(resp_valid_out), 0);
    req_valid_in = 4'b1001;
    #1;
    check("rmid_grant0", 32'(req_ready_out), 32'h1);
    tick();
    req_valid_in = 4'b1000;
    tick();
    check("rmid_resp_id", 32'(resp_id_out), 0);
    check("rmid_resp_quot", 32'(resp_quotient_out), 32'(23 / 2));
    resp_ready_in = 1'b1;
    tick();
    check("rmid_grant3", 32'(req_ready_out), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
